// File: rtl/mem_selftest.sv
// Memory self-test: fills an internal RAM with a Galois LFSR pattern, reads it
// back against the regenerated pattern and reports a saturating mismatch count.
module mem_selftest #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inject_fault,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_WIDTH:0] err_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Feedback masks for maximal-length right-shifting Galois LFSRs.
  function automatic logic [63:0] mask_for_width(input int w);
    logic [63:0] m;
    case (w)
      4:       m = 64'h0000_0000_0000_000C;
      5:       m = 64'h0000_0000_0000_0014;
      6:       m = 64'h0000_0000_0000_0030;
      7:       m = 64'h0000_0000_0000_0060;
      8:       m = 64'h0000_0000_0000_00B8;
      16:      m = 64'h0000_0000_0000_B400;
      32:      m = 64'h0000_0000_8020_0003;
      default: m = 64'h0000_0000_0000_00B8;
    endcase
    return m;
  endfunction

  localparam logic [DATA_WIDTH-1:0] LFSR_MASK = DATA_WIDTH'(mask_for_width(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SEED_EFF  =
      (SEED == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : SEED;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   ERR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    start_dly_q, start_dly_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    mism_q, mism_d;
  logic [ADDR_WIDTH:0]     err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;

  logic                    start_edge;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign start_edge = start & ~start_dly_q;

  always_comb begin
    state_d     = state_q;
    start_dly_d = start;
    addr_d      = addr_q;
    lfsr_d      = lfsr_q;
    exp_d       = exp_q;
    rd_vld_d    = 1'b0;
    mism_d      = rd_vld_q && (rd_data_q != exp_q);
    err_d       = (mism_q && (err_q != ERR_MAX)) ? err_q + ERR_ONE : err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wdata   = {lfsr_q[DATA_WIDTH-1:1], lfsr_q[0] ^ inject_fault};

    case (state_q)
      IDLE, DONE: begin
        // The last mismatch lands one edge after DONE is entered, so done and
        // pass are published on that edge from the final count.
        if ((state_q == DONE) && !done_q) begin
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end
        if (start_edge) begin
          state_d = WRITE;
          addr_d  = '0;
          lfsr_d  = SEED_EFF;
          err_d   = '0;
          mism_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        lfsr_d = lfsr_next(lfsr_q);
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          lfsr_d  = SEED_EFF;
          state_d = READ;
        end
      end
      READ: begin
        mem_re   = 1'b1;
        exp_d    = lfsr_q;
        rd_vld_d = 1'b1;
        lfsr_d   = lfsr_next(lfsr_q);
        addr_d   = addr_q + ADDR_ONE;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      addr_q      <= '0;
      lfsr_q      <= SEED_EFF;
      exp_q       <= '0;
      rd_vld_q    <= 1'b0;
      mism_q      <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      addr_q      <= addr_d;
      lfsr_q      <= lfsr_d;
      exp_q       <= exp_d;
      rd_vld_q    <= rd_vld_d;
      mism_q      <= mism_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // RAM is deliberately unreset: every run rewrites all words before reading.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
    if (mem_re) rd_data_q <= mem[addr_q];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mem_selftest.sv
// Directed and randomized runs of mem_selftest checked against a word-level
// model of what ends up stored in the RAM versus what the readback expects.
module tb_mem_selftest;

  logic       clk;
  logic       rst;
  logic       start;
  logic       inject_fault;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;

  int checks   = 0;
  int failures = 0;

  mem_selftest #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .inject_fault(inject_fault),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: pattern from the seed, stored word = pattern with bit 0 flipped
  // where a fault was injected; errors = words whose readback differs.
  function automatic int model_errors(input logic [15:0] mask);
    logic [7:0] pattern [16];
    logic [7:0] stored  [16];
    logic [7:0] v;
    int         cnt;
    v = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      pattern[i] = v;
      v = (v >> 1) ^ ((v & 8'h01) != 0 ? 8'hB8 : 8'h00);
    end
    for (int i = 0; i < 16; i++) stored[i] = pattern[i] ^ {7'b0, mask[i]};
    cnt = 0;
    for (int i = 0; i < 16; i++) if (stored[i] != pattern[i]) cnt++;
    if (cnt > 31) cnt = 31;
    return cnt;
  endfunction

  // Edge 0 is the edge that samples the start edge; write k happens on edge k+1.
  task automatic do_run(input logic [15:0] mask, input int hold, input int pulse_at,
                        input string tag);
    int          first_done;
    int          exp_err;
    logic [31:0] err_at_done;
    logic        pass_at_done;
    exp_err      = model_errors(mask);
    first_done   = -1;
    err_at_done  = '1;
    pass_at_done = 1'bx;
    start        = 1'b1;
    inject_fault = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk); #1;
      inject_fault = (e < 16) ? mask[e[3:0]] : 1'b0;
      start        = (e + 1 < hold) || (e + 1 == pulse_at);
      if (e == 0) begin
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_done_e0"}, done, 0);
        check({tag, "_err_e0"}, err_count, 0);
      end
      if (e == 20) check({tag, "_busy_e20"}, busy, 1);
      if ((done === 1'b1) && (first_done < 0)) begin
        first_done   = e;
        err_at_done  = 32'(err_count);
        pass_at_done = pass;
      end
    end
    check({tag, "_done_edge"}, first_done, 34);
    check({tag, "_err"}, err_at_done, exp_err);
    check({tag, "_pass"}, pass_at_done, (exp_err == 0) ? 1 : 0);
    check({tag, "_done_hold"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_err_hold"}, err_count, exp_err);
  endtask

  initial begin
    logic [15:0] m;
    rst          = 1'b1;
    start        = 1'b0;
    inject_fault = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    do_run(16'h0000, 3, -1, "basic");
    do_run(16'h0070, 3, -1, "fault3");
    do_run(16'h0000, 3, -1, "rerun");
    do_run(16'hFFFF, 3, -1, "fullfault");
    do_run(16'h0000, 3, 22, "ignore");
    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom_range(0, 16'hFFFF));
      do_run(m, 1 + int'($urandom_range(0, 4)), -1, $sformatf("rand%0d", r));
    end

    start = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_err", err_count, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    do_run(16'h0000, 1000, -1, "rst_rerun");
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
